shift_unit_seq: RTL and testbench

- Parametrised multi-cycle shifter for the ALU shift path. Generalises the fixed 1-bit logical shift to configurable width, variable shift amount, four shift modes and a configurable number of bits shifted per clock.
- The operand is loaded on a start/busy/done handshake and shifted iteratively.
- The result is registered and held until the next operation completes, so the datapath can trade area against latency.

---
 rtl/shift_unit_seq.sv | 141 ++++++++++++++
 tb/tb_shift_unit_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle shifter for the ALU shift path.
// It accepts an operand on a start/busy/done handshake and shifts it by up to
// STEP bits per clock. The result stays registered until the next operation
// completes.
//
// Parameters:
//   WIDTH - operand/result width (power of 2, >= 2)
//   STEP  - maximum bits shifted per clock (power of 2, <= WIDTH)
//
// Ports:
//   clock   - system clock, rising edge
//   resetn  - asynchronous active-low reset
//   start   - request; accepted only while busy=0
//   op      - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data_in - operand, sampled on accept
//   amount  - shift distance 0..WIDTH-1, sampled on accept
//   busy    - high while an operation is in flight
//   done    - one-cycle completion pulse
//   result  - shifted value, held between operations
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH)-1:0] amount,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result
);

  localparam int AW = $clog2(WIDTH);
  // The per-cycle distance only needs to span 0..STEP. Keeping it this narrow
  // confines each cycle to a STEP-wide mux rather than a full barrel shifter.
  localparam int SW = $clog2(STEP) + 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef enum logic [1:0] {SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11} mode_t;

  state_t           state, state_nxt;
  mode_t            mode, mode_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic             busy_nxt, done_nxt;
  logic [WIDTH-1:0] result_nxt;

  logic [SW-1:0]      k;
  logic [WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0] rot_dbl;

  // The per-cycle distance is clamped to the remaining count, so the counter
  // cannot underflow.
  always_comb begin
    if ({1'b0, cnt} >= CW'(STEP)) k = SW'(STEP);
    else                          k = SW'(cnt);
  end

  always_comb begin
    shifted = sreg;
    rot_dbl = {sreg, sreg} >> k;
    unique case (mode)
      SLL: shifted = sreg << k;
      SRL: shifted = sreg >> k;
      SRA: shifted = $signed(sreg) >>> k;
      ROR: shifted = rot_dbl[WIDTH-1:0];
      default: shifted = sreg;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath/output next values
  always_comb begin
    sreg_nxt   = sreg;
    cnt_nxt    = cnt;
    mode_nxt   = mode;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    result_nxt = result;
    unique case (state)
      IDLE: begin
        if (start) begin
          sreg_nxt = data_in;
          cnt_nxt  = amount;
          mode_nxt = mode_t'(op);
          busy_nxt = 1'b1;
        end
      end
      RUN: begin
        if (cnt != '0) begin
          sreg_nxt = shifted;
          cnt_nxt  = cnt - AW'(k);
        end
      end
      FINISH: begin
        result_nxt = sreg;
        done_nxt   = 1'b1;
        busy_nxt   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sreg   <= '0;
      cnt    <= '0;
      mode   <= SLL;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      sreg   <= sreg_nxt;
      cnt    <= cnt_nxt;
      mode   <= mode_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: drives two shift_unit_seq instances (STEP=1 and STEP=4,
// WIDTH=32). Directed and random operations are compared against a
// shift/latency reference model in the bench.
`timescale 1ns/1ps
module tb_shift_unit_seq;

  logic        clock;
  logic        resetn;
  logic        start_v [2];
  logic [1:0]  op_v    [2];
  logic [31:0] din_v   [2];
  logic [4:0]  amt_v   [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [31:0] res_v   [2];
  logic [31:0] prev    [2];

  int n_cmp = 0;
  int n_bad = 0;

  shift_unit_seq #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clock(clock), .resetn(resetn), .start(start_v[0]), .op(op_v[0]),
    .data_in(din_v[0]), .amount(amt_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .result(res_v[0]));

  shift_unit_seq #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clock(clock), .resetn(resetn), .start(start_v[1]), .op(op_v[1]),
    .data_in(din_v[1]), .amount(amt_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .result(res_v[1]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int a);
    logic [63:0] w;
    case (o)
      2'b00: return d << a;
      2'b01: return d >> a;
      2'b10: begin w = {{32{d[31]}}, d}; w = w >> a; return w[31:0]; end
      default: begin w = {d, d}; w = w >> a; return w[31:0]; end
    endcase
  endfunction

  // One complete operation on instance s. With junk set, start is held high
  // with fresh random operands for the whole busy window; it must be ignored.
  task automatic run_op(input int s, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] a, input bit junk);
    int step, lat, exp_lat;
    bit seen;
    logic [31:0] exp_r;
    step    = (s == 0) ? 1 : 4;
    exp_lat = (int'(a) + step - 1) / step + 2;
    exp_r   = ref_shift(o, d, int'(a));
    @(negedge clock);
    start_v[s] = 1'b1; op_v[s] = o; din_v[s] = d; amt_v[s] = a;
    @(posedge clock);
    #1;
    start_v[s] = junk;
    op_v[s] = 2'($urandom); din_v[s] = $urandom; amt_v[s] = 5'($urandom);
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (done_v[s]) seen = 1;
      else begin
        check($sformatf("busy_in_flight[%0d]", s), 32'(busy_v[s]), 32'd1);
        check($sformatf("result_held[%0d]", s), res_v[s], prev[s]);
        if (junk) begin
          op_v[s] = 2'($urandom); din_v[s] = $urandom; amt_v[s] = 5'($urandom);
        end
      end
    end
    start_v[s] = 1'b0;
    check($sformatf("latency[%0d] op=%0d amt=%0d", s, o, a), 32'(lat), 32'(exp_lat));
    check($sformatf("result[%0d] op=%0d d=%h amt=%0d", s, o, d, a), res_v[s], exp_r);
    check($sformatf("busy_at_done[%0d]", s), 32'(busy_v[s]), 32'd0);
    prev[s] = exp_r;
  endtask

  task automatic idle_check(input int s);
    @(posedge clock);
    #1;
    check($sformatf("done_cleared[%0d]", s), 32'(done_v[s]), 32'd0);
    check($sformatf("idle_busy[%0d]", s), 32'(busy_v[s]), 32'd0);
    check($sformatf("idle_result[%0d]", s), res_v[s], prev[s]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_activity;
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; op_v[i] = '0; din_v[i] = '0; amt_v[i] = '0; prev[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("reset_done[%0d]", i), 32'(done_v[i]), 32'd0);
      check($sformatf("reset_result[%0d]", i), res_v[i], 32'd0);
    end
    @(negedge clock);
    resetn = 1'b1;

    run_op(0, 2'b01, 32'h8000_0001, 5'd1, 0);
    idle_check(0);
    run_op(0, 2'b10, 32'h8000_0000, 5'd31, 0);
    idle_check(0);
    run_op(0, 2'b01, 32'h8000_0000, 5'd31, 0);
    idle_check(0);
    run_op(1, 2'b11, 32'h1234_5678, 5'd7, 0);
    idle_check(1);
    run_op(1, 2'b00, 32'h1234_5678, 5'd7, 0);
    idle_check(1);
    run_op(1, 2'b00, 32'hDEAD_BEEF, 5'd0, 1);
    // Back-to-back: the next start is raised while done is still high.
    run_op(1, 2'b00, 32'h0000_0001, 5'd4, 0);
    idle_check(1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clock);
    start_v[0] = 1'b1; op_v[0] = 2'b01; din_v[0] = $urandom; amt_v[0] = 5'd20;
    @(posedge clock);
    #1;
    start_v[0] = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midreset_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("midreset_done[%0d]", i), 32'(done_v[i]), 32'd0);
      check($sformatf("midreset_result[%0d]", i), res_v[i], 32'd0);
      prev[i] = '0;
    end
    @(negedge clock);
    resetn = 1'b1;
    any_activity = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (done_v[0] || busy_v[0]) any_activity = 1;
    end
    check("no_done_after_reset", 32'(any_activity), 32'd0);
    run_op(0, 2'b00, 32'h0000_00F0, 5'd3, 0);
    idle_check(0);

    for (int i = 0; i < 40; i++) begin
      int s;
      s = i % 2;
      run_op(s, 2'($urandom), $urandom, 5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
